ntt_ctrl: RTL and testbench

- Sequencer for one forward Kyber NTT (N=256, q=3329) on a single shared butterfly unit.
- Walks 7 layers × 128 butterflies and issues coefficient-RAM read addresses plus the zeta-ROM index for each butterfly.
- Delays those addresses through the datapath latency and issues the matching write-back.
- Sits between the top-level start/done handshake and the coefficient RAM / zeta ROM / butterfly datapath.

---
 rtl/ntt_pkg.sv | 26 ++
 rtl/ntt_addr_gen.sv | 36 +++
 rtl/ntt_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ntt_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and types for the Kyber forward-NTT sequencer.
//   - Kyber transform geometry (N, LOG_N, NUM_LAYERS, BFLY_PER_LAYER, KYBER_Q)
//   - sequencer state enum
//   - width typedefs for coefficient addresses, zeta indices, layer and
//     butterfly counters
package ntt_pkg;

    localparam int N              = 256;
    localparam int LOG_N          = 8;
    localparam int NUM_LAYERS     = 7;
    localparam int BFLY_PER_LAYER = 128;
    localparam int KYBER_Q        = 3329;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef logic [LOG_N-1:0] addr_t;   // coefficient RAM address, 0..255
    typedef logic [6:0]       zeta_t;   // zeta ROM index, 0..127
    typedef logic [2:0]       layer_t;  // layer 0..6
    typedef logic [6:0]       bfly_t;   // butterfly within a layer, 0..127

endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: combinational butterfly address generator.
//   layer     in  : current NTT layer L (0..6)
//   bfly      in  : butterfly index b within the layer (0..127)
//   addr_a    out : upper coefficient address j
//   addr_b    out : lower coefficient address j+len
//   zeta_addr out : zeta ROM index k
// With len = 128>>L, the butterfly index splits into a group number (high
// bits) and an offset inside the group (low bits); each group spans 2*len
// coefficients and consumes one zeta.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [2:0] layer,
    input  logic [6:0] bfly,
    output logic [7:0] addr_a,
    output logic [7:0] addr_b,
    output logic [6:0] zeta_addr
);

    logic [7:0] len;
    logic [6:0] group;
    logic [6:0] offset;
    logic [8:0] base;

    always_comb begin
        len       = 8'd128 >> layer;
        group     = bfly >> (3'd7 - layer);
        offset    = bfly & 7'(len - 8'd1);
        // group * 2 * len == group << (8 - L); always below 256
        base      = {2'b00, group} << (4'd8 - {1'b0, layer});
        addr_a    = base[7:0] + {1'b0, offset};
        addr_b    = addr_a + len;
        zeta_addr = (7'd1 << layer) + group;
    end

endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: sequencer for one forward Kyber NTT on a single shared butterfly.
//   clk        in  : system clock (rising edge)
//   rst_n      in  : synchronous active-low reset
//   start      in  : one-cycle run request, honoured only in IDLE
//   busy       out : high while reads are issued or drained
//   done       out : one-cycle pulse after the final write
//   rd_en      out : read strobe for coefficient pair and zeta
//   rd_addr_a  out : upper coefficient address j
//   rd_addr_b  out : lower coefficient address j+len
//   zeta_addr  out : zeta ROM index
//   wr_en      out : write strobe, rd_en delayed PIPE_LAT cycles
//   wr_addr_a  out : destination of a+bw
//   wr_addr_b  out : destination of a-bw
//   layer      out : current layer 0..6
// PIPE_LAT (1..4) is the read-to-writeback latency of the datapath.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int PIPE_LAT = 2,
    parameter int N        = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] zeta_addr,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b,
    output logic [2:0] layer
);

    localparam int LAST_BFLY = N / 2 - 1;

    state_t     state_reg, state_next;
    logic [6:0] bfly_reg, bfly_next;
    logic [2:0] layer_reg, layer_next;
    logic [1:0] drain_reg, drain_next;

    logic [7:0] gen_a, gen_b;
    logic [6:0] gen_z;

    logic                     rd_en_int;
    logic [PIPE_LAT-1:0]      valid_pipe;
    logic [PIPE_LAT-1:0][7:0] a_pipe;
    logic [PIPE_LAT-1:0][7:0] b_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bfly_reg  <= '0;
            layer_reg <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            bfly_reg  <= bfly_next;
            layer_reg <= layer_next;
            drain_reg <= drain_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bfly_next  = bfly_reg;
        layer_next = layer_reg;
        drain_next = drain_reg;
        rd_en_int  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                    bfly_next  = '0;
                    layer_next = '0;
                    drain_next = '0;
                end
            end
            ISSUE: begin
                rd_en_int = 1'b1;
                busy      = 1'b1;
                if (bfly_reg == 7'(LAST_BFLY)) begin
                    bfly_next  = '0;
                    drain_next = '0;
                    state_next = DRAIN;
                end else begin
                    bfly_next = bfly_reg + 7'd1;
                end
            end
            DRAIN: begin
                // Hold off reads until every write of this layer has landed.
                busy = 1'b1;
                if (drain_reg == 2'(PIPE_LAT - 1)) begin
                    drain_next = '0;
                    if (layer_reg == 3'(NUM_LAYERS - 1)) begin
                        state_next = FINISH;
                    end else begin
                        layer_next = layer_reg + 3'd1;
                        state_next = ISSUE;
                    end
                end else begin
                    drain_next = drain_reg + 2'd1;
                end
            end
            FINISH: begin
                // start is deliberately not looked at here.
                done       = 1'b1;
                layer_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    ntt_addr_gen u_addr_gen (
        .layer     (layer_reg),
        .bfly      (bfly_reg),
        .addr_a    (gen_a),
        .addr_b    (gen_b),
        .zeta_addr (gen_z)
    );

    // Addresses are forced to zero when no read is issued so idle outputs
    // are quiet and the delay line carries zeros with its invalid slots.
    assign rd_en     = rd_en_int;
    assign rd_addr_a = rd_en_int ? gen_a : '0;
    assign rd_addr_b = rd_en_int ? gen_b : '0;
    assign zeta_addr = rd_en_int ? gen_z : '0;
    assign layer     = layer_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        valid_pipe[0] <= 1'b0;
                        a_pipe[0]     <= '0;
                        b_pipe[0]     <= '0;
                    end else begin
                        valid_pipe[0] <= rd_en_int;
                        a_pipe[0]     <= rd_addr_a;
                        b_pipe[0]     <= rd_addr_b;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        valid_pipe[gi] <= 1'b0;
                        a_pipe[gi]     <= '0;
                        b_pipe[gi]     <= '0;
                    end else begin
                        valid_pipe[gi] <= valid_pipe[gi-1];
                        a_pipe[gi]     <= a_pipe[gi-1];
                        b_pipe[gi]     <= b_pipe[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign wr_en     = valid_pipe[PIPE_LAT-1];
    assign wr_addr_a = a_pipe[PIPE_LAT-1];
    assign wr_addr_b = b_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: self-checking bench for ntt_ctrl with a cycle-level model
// derived from the loop-form Kyber NTT, plus a butterfly/RAM model whose
// final contents are compared with a software NTT.
module tb_ntt_ctrl;

    localparam int P   = 2;
    localparam int Q   = 3329;
    localparam int CYC = 128 + P;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done, rd_en, wr_en;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] zeta_addr;
    logic [2:0] layer;

    ntt_ctrl #(.PIPE_LAT(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .zeta_addr (zeta_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .layer     (layer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int mt    = -1;      // model cycle index since start acceptance, -1 = idle
    bit armed = 0;
    int wr_total = 0;

    int exp_a [896];
    int exp_b [896];
    int exp_z [896];
    int zetas [128];
    int mem   [256];
    int cur_ref [256];
    int next_ref [256];
    int w [256];
    int pend_a [$];
    int pend_b [$];
    int pend_z [$];

    // literal expectations taken by hand from the loop-form algorithm
    int lt_t [8] = '{1, 128, 131, 195, 781, 782, 783, 908};
    int lt_a [8] = '{0, 127, 0, 128, 0, 1, 4, 253};
    int lt_b [8] = '{128, 255, 64, 192, 2, 3, 6, 255};
    int lt_z [8] = '{1, 1, 2, 3, 64, 64, 65, 127};

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s t=%0d actual=%0d required=%0d", name, mt, act, req);
        end
    endtask

    task automatic build_tables();
        int k, n, len, st, e, z;
        k = 1;
        n = 0;
        for (len = 128; len >= 2; len = len / 2) begin
            for (st = 0; st < 256; st = st + 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    exp_a[n] = j;
                    exp_b[n] = j + len;
                    exp_z[n] = k;
                    n++;
                end
                k++;
            end
        end
        for (int i = 0; i < 128; i++) begin
            e = 0;
            for (int bt = 0; bt < 7; bt++) if (((i >> bt) & 1) != 0) e = e | (1 << (6 - bt));
            z = 1;
            for (int r = 0; r < e; r++) z = (z * 17) % Q;
            zetas[i] = z;
        end
    endtask

    // software reference NTT on the work array w
    task automatic ntt_work();
        int k, t, z;
        k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                z = zetas[k];
                k++;
                for (int j = st; j < st + len; j++) begin
                    t = (z * w[j + len]) % Q;
                    w[j + len] = (w[j] - t + Q) % Q;
                    w[j] = (w[j] + t) % Q;
                end
            end
        end
    endtask

    task automatic load_and_ref(input bit ones);
        for (int i = 0; i < 256; i++) begin
            mem[i] = ones ? 1 : int'($urandom_range(0, Q - 1));
            w[i] = mem[i];
        end
        ntt_work();
        for (int i = 0; i < 256; i++) cur_ref[i] = w[i];
    endtask

    // one clock: advance the model on the edge, then compare DUT to model
    task automatic step();
        int e_rd, e_a, e_b, e_z, e_wr, e_wa, e_wb, e_busy, e_done, e_layer;
        int u, n, tw, va, vb, vz, t;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mt = -1;
            armed = 1;
            pend_a.delete();
            pend_b.delete();
            pend_z.delete();
        end else if (mt >= 1) begin
            mt++;
            if (mt == 7 * CYC + 2) mt = -1;
        end else if (start) begin
            mt = 1;
        end
        if (!armed) return;

        e_rd = 0; e_a = 0; e_b = 0; e_z = 0; e_wr = 0; e_wa = 0; e_wb = 0;
        e_busy = 0; e_done = 0; e_layer = 0;
        if (mt >= 1) begin
            u = mt - 1;
            if (u < 7 * CYC) begin
                e_busy = 1;
                e_layer = u / CYC;
                if ((u % CYC) < 128) begin
                    n = (u / CYC) * 128 + (u % CYC);
                    e_rd = 1; e_a = exp_a[n]; e_b = exp_b[n]; e_z = exp_z[n];
                end
            end else begin
                e_done = 1;
                e_layer = 6;
            end
            tw = mt - P;
            if (tw >= 1 && (tw - 1) < 7 * CYC && ((tw - 1) % CYC) < 128) begin
                n = ((tw - 1) / CYC) * 128 + ((tw - 1) % CYC);
                e_wr = 1; e_wa = exp_a[n]; e_wb = exp_b[n];
            end
        end
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        chk("layer", int'(layer), e_layer);
        chk("rd_en", int'(rd_en), e_rd);
        chk("rd_addr_a", int'(rd_addr_a), e_a);
        chk("rd_addr_b", int'(rd_addr_b), e_b);
        chk("zeta_addr", int'(zeta_addr), e_z);
        chk("wr_en", int'(wr_en), e_wr);
        chk("wr_addr_a", int'(wr_addr_a), e_wa);
        chk("wr_addr_b", int'(wr_addr_b), e_wb);

        for (int i = 0; i < 8; i++) begin
            if (mt == lt_t[i]) begin
                chk("lit_rd_en", int'(rd_en), 1);
                chk("lit_rd_a", int'(rd_addr_a), lt_a[i]);
                chk("lit_rd_b", int'(rd_addr_b), lt_b[i]);
                chk("lit_zeta", int'(zeta_addr), lt_z[i]);
            end
        end
        if (mt == 911) begin
            chk("lit_done911", int'(done), 1);
            chk("lit_busy911", int'(busy), 0);
        end

        // butterfly + RAM model driven by the DUT strobes
        if (rst_n) begin
            if (mt == 1) wr_total = 0;
            if (rd_en) begin
                pend_a.push_back(mem[rd_addr_a]);
                pend_b.push_back(mem[rd_addr_b]);
                pend_z.push_back(zetas[zeta_addr]);
            end
            if (wr_en) begin
                chk("pend_nonempty", (pend_a.size() > 0) ? 1 : 0, 1);
                if (pend_a.size() > 0) begin
                    va = pend_a.pop_front();
                    vb = pend_b.pop_front();
                    vz = pend_z.pop_front();
                    t = (vz * vb) % Q;
                    mem[wr_addr_a] = (va + t) % Q;
                    mem[wr_addr_b] = (va - t + Q) % Q;
                end
                wr_total++;
            end
            if (mt == 911) begin
                chk("write_count", wr_total, 896);
                for (int i = 0; i < 256; i++) chk("ntt_coef", mem[i], cur_ref[i]);
            end
        end
    endtask

    task automatic wait_t(input int target);
        int budget;
        budget = 3000;
        while (mt != target && budget > 0) begin
            step();
            budget--;
        end
        if (mt != target) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_t actual=%0d required=%0d", mt, target);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        build_tables();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // run 1: all-ones input, stray start pulses at cycles 5 and 500
        load_and_ref(1'b1);
        pulse_start();
        wait_t(5);
        pulse_start();
        wait_t(500);
        pulse_start();
        wait_t(911);
        repeat (3) step();

        // run 2: random input; start held high through FINISH begins run 3
        load_and_ref(1'b0);
        for (int i = 0; i < 256; i++) w[i] = cur_ref[i];
        ntt_work();
        for (int i = 0; i < 256; i++) next_ref[i] = w[i];
        pulse_start();
        wait_t(910);
        start = 1'b1;
        step();
        for (int i = 0; i < 256; i++) cur_ref[i] = next_ref[i];
        step();
        step();
        chk("restart_after_finish", mt, 1);
        start = 1'b0;
        wait_t(911);
        repeat (3) step();

        // run 4: reset for one cycle at cycle 300, no done must follow
        load_and_ref(1'b0);
        pulse_start();
        wait_t(300);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (20) step();

        // run 5: clean transform after the abort
        load_and_ref(1'b0);
        pulse_start();
        wait_t(911);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
